// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR result averager.
package sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT_EOC,
        ST_RELEASE,
        ST_OUTPUT
    } sar_state_e;

    localparam int SAR_N_BITS_DEF  = 10;
    localparam int SAR_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sar_result_averager_if.sv
// ADC-side and consumer-side signals of the averager, bundled for port hookup.
interface sar_result_averager_if #(
    parameter int N_BITS = sar_pkg::SAR_N_BITS_DEF
) ();
    logic              start_digital;
    logic              input_hold_digital;
    logic              eoc;
    logic [N_BITS-1:0] adc_result_digital;
    logic [N_BITS-1:0] avg_result_digital;
    logic              avg_valid;
    logic              avg_ready;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  start_digital, eoc, adc_result_digital, avg_ready,
        output input_hold_digital, avg_result_digital, avg_valid, busy, timeout_err
    );

    modport master (
        output start_digital, eoc, adc_result_digital, avg_ready,
        input  input_hold_digital, avg_result_digital, avg_valid, busy, timeout_err
    );
endinterface

// File: rtl/sar_accumulator.sv
// Sums 2^AVG_LOG2 ADC samples; width is sized so the full sum can never wrap.
module sar_accumulator #(
    parameter int N_BITS   = sar_pkg::SAR_N_BITS_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       add_i,
    input  logic [N_BITS-1:0]          sample_i,
    output logic [N_BITS+AVG_LOG2-1:0] sum_o,
    output logic [AVG_LOG2:0]          count_o,
    output logic                       done_o
);
    localparam int SW = N_BITS + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] N_SAMPLES = CW'(2 ** AVG_LOG2);

    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + SW'(sample_i);
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign sum_o   = sum_q;
    assign count_o = cnt_q;
    assign done_o  = (cnt_q == N_SAMPLES);

    // A sample arriving once the window is full would break the no-wrap sizing.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (add_i && !clear_i) |-> (cnt_q < N_SAMPLES));

endmodule

// File: rtl/sar_result_averager.sv
// Sequences hold/convert cycles on a SAR ADC and presents the truncated mean
// of 2^AVG_LOG2 results through a valid/ready handshake.
module sar_result_averager
    import sar_pkg::*;
#(
    parameter int N_BITS   = SAR_N_BITS_DEF,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = SAR_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sar_result_averager_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    sar_state_e state_q, state_d;
    logic          eoc_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          eoc_rise;
    logic          acc_clear, acc_add, acc_done;
    logic [N_BITS+AVG_LOG2-1:0] acc_sum;
    logic [AVG_LOG2:0]          acc_count;

    assign eoc_rise = bus.eoc & ~eoc_q;

    sar_accumulator #(
        .N_BITS   (N_BITS),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (acc_clear),
        .add_i    (acc_add),
        .sample_i (bus.adc_result_digital),
        .sum_o    (acc_sum),
        .count_o  (acc_count),
        .done_o   (acc_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            eoc_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eoc_q   <= bus.eoc;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                acc_clear = 1'b1;
                tmo_d     = '0;
                if (bus.start_digital) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                tmo_d   = '0;
                state_d = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                // A capture on the last allowed cycle beats the timeout.
                if (eoc_rise) begin
                    acc_add = 1'b1;
                    state_d = ST_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    acc_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RELEASE: state_d = acc_done ? ST_OUTPUT : ST_HOLD;
            ST_OUTPUT:  if (bus.avg_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign bus.input_hold_digital = (state_q == ST_HOLD) || (state_q == ST_WAIT_EOC);
    assign bus.avg_valid          = (state_q == ST_OUTPUT);
    assign bus.busy               = (state_q != ST_IDLE);
    assign bus.timeout_err        = err_q;
    assign bus.avg_result_digital = acc_sum[N_BITS+AVG_LOG2-1 -: N_BITS];

    a_valid_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.avg_valid && !bus.avg_ready) |=> (bus.avg_valid && $stable(bus.avg_result_digital)));
    a_hold_low: assert property (@(posedge clk)
        (state_q inside {ST_IDLE, ST_RELEASE, ST_OUTPUT}) |-> !bus.input_hold_digital);

endmodule

// File: doc/sar_result_averager.md
SAR_RESULT_AVERAGER -- requirements
Module: sar_result_averager

Interface
REQ-001 Parameter N_BITS, default 10, ADC result width.
REQ-002 Parameter AVG_LOG2, default 2, log2 of samples averaged per output (0..4).
REQ-003 Parameter TIMEOUT, default 64, max clk cycles waiting for eoc.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_digital  in  1  request one averaged result; sampled only in IDLE.
REQ-007 input_hold_digital  out  1  drives ADC hold/convert input.
REQ-008 eoc  in  1  ADC end-of-conversion.
REQ-009 adc_result_digital  in  N_BITS  ADC output_result_digital.
REQ-010 avg_result_digital  out  N_BITS  averaged result.
REQ-011 avg_valid  out  1  avg_result_digital valid.
REQ-012 avg_ready  in  1  consumer accepts when avg_valid & avg_ready.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 timeout_err  out  1  sticky; set on eoc timeout.

Function
REQ-015 FSM states: IDLE, HOLD, WAIT_EOC, RELEASE, OUTPUT.
REQ-016 IDLE: start_digital=1 -> HOLD next cycle; sample count and accumulator cleared.
REQ-017 HOLD: input_hold_digital=1; -> WAIT_EOC next cycle.
REQ-018 WAIT_EOC: input_hold_digital stays 1; eoc rising edge (eoc=1, registered eoc_q=0) captures adc_result_digital into accumulator same edge -> RELEASE.
REQ-019 eoc already high on WAIT_EOC entry is not an edge; a new rising edge is required.
REQ-020 RELEASE: input_hold_digital=0 for exactly one cycle; if samples taken < 2^AVG_LOG2 -> HOLD, else -> OUTPUT.
REQ-021 Accumulator width N_BITS+AVG_LOG2; never overflows; avg_result_digital = accumulator >> AVG_LOG2 (truncation).
REQ-022 OUTPUT: avg_valid=1, avg_result_digital stable until handshake; handshake -> IDLE next cycle.
REQ-023 avg_valid never deasserts without handshake except by reset.
REQ-024 Timeout counter runs in WAIT_EOC only, cleared on state entry; reaching TIMEOUT cycles without an edge sets timeout_err, discards partial sum, -> IDLE, input_hold_digital=0.
REQ-025 timeout_err clears only on reset; does not block further starts.
REQ-026 start_digital outside IDLE ignored (no queueing).
REQ-027 Eoc edge and timeout on same cycle: sample taken, no timeout.
REQ-028 Latency with eoc edge at k cycles after HOLD entry: avg_valid rises 2^AVG_LOG2*(k+2)+1 cycles after start sampled.

Reset
REQ-029 On reset: state IDLE; input_hold_digital=0, avg_valid=0, avg_result_digital=0, busy=0, timeout_err=0, accumulator, counters, eoc_q =0.
REQ-030 Reset mid-operation abandons conversion; input_hold_digital=0 on the cycle after reset sampled.

Structure
REQ-031 Shared package sar_pkg holds state enum, default N_BITS, default TIMEOUT.
REQ-032 One sub-module sar_accumulator (clear, add-enable, sample count, done flag).
REQ-033 Formal properties: avg_valid stability, hold low in IDLE/RELEASE/OUTPUT, accumulator no overflow.

Verification
REQ-034 AVG_LOG2=2, results 100,104,108,112, avg_ready=1 -> avg_result_digital=106, one avg_valid pulse.
REQ-035 AVG_LOG2=2, all results 1023 -> 1023, no overflow.
REQ-036 avg_ready low 20 cycles in OUTPUT -> avg_valid and value 106 held 20 cycles, IDLE one cycle after accept.
REQ-037 eoc never rises, TIMEOUT=64 -> timeout_err=1 at cycle 64 of WAIT_EOC, IDLE, hold low; next start completes normally.
REQ-038 reset asserted during second sample -> all outputs 0 next cycle; new start gives correct average from fresh samples.
REQ-039 start_digital pulsed while busy, eoc held high across HOLD entry -> start ignored, no capture until eoc falls and rises.
